uart_cmd_master: RTL

//  Host-side initiator for the ASCII register protocol ("wb AA DD\n" / "rb AA\n").

---
 rtl/uart_cmd_pkg.sv | 64 ++++++
 rtl/uart_rsp_parser.sv | 93 +++++++++
 rtl/uart_cmd_master.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types, ASCII constants and nibble/command helpers for the host-side
// ASCII register protocol ("wb AA DD\n" / "rb AA\n").
package uart_cmd_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 24;

  localparam logic [BYTE_W-1:0] ASCII_W  = 8'h77;
  localparam logic [BYTE_W-1:0] ASCII_R  = 8'h72;
  localparam logic [BYTE_W-1:0] ASCII_B  = 8'h62;
  localparam logic [BYTE_W-1:0] ASCII_SP = 8'h20;
  localparam logic [BYTE_W-1:0] ASCII_NL = 8'h0a;
  localparam logic [BYTE_W-1:0] ASCII_0  = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_9  = 8'h39;
  localparam logic [BYTE_W-1:0] ASCII_A  = 8'h61;
  localparam logic [BYTE_W-1:0] ASCII_F  = 8'h66;

  // Index of the trailing '\n' in each command
  localparam logic [IDX_W-1:0] WR_LAST_IDX = 4'd8;
  localparam logic [IDX_W-1:0] RD_LAST_IDX = 4'd5;

  typedef enum logic [1:0] {M_IDLE, M_SEND, M_WAIT, M_DONE} mst_state_e;
  typedef enum logic [2:0] {P_IDLE, P_WAIT_HI, P_WAIT_LO, P_WAIT_NL, P_DRAIN} rsp_state_e;

  typedef struct packed {
    logic              write;
    logic [BYTE_W-1:0] addr;
    logic [BYTE_W-1:0] wdata;
  } cmd_req_t;

  function automatic logic [BYTE_W-1:0] nib2asc(input logic [NIB_W-1:0] n);
    if (n < NIB_W'(10)) return ASCII_0 + BYTE_W'(n);
    return ASCII_A + BYTE_W'(n) - BYTE_W'(10);
  endfunction

  function automatic logic is_hex(input logic [BYTE_W-1:0] b);
    return ((b >= ASCII_0) && (b <= ASCII_9)) || ((b >= ASCII_A) && (b <= ASCII_F));
  endfunction

  function automatic logic [NIB_W-1:0] asc2nib(input logic [BYTE_W-1:0] b);
    if (b <= ASCII_9) return NIB_W'(b - ASCII_0);
    return NIB_W'(b - ASCII_A + BYTE_W'(10));
  endfunction

  // Byte 'idx' of the command text for request r
  function automatic logic [BYTE_W-1:0] cmd_byte(input cmd_req_t r, input logic [IDX_W-1:0] idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      4'd0:    b = r.write ? ASCII_W : ASCII_R;
      4'd1:    b = ASCII_B;
      4'd2:    b = ASCII_SP;
      4'd3:    b = nib2asc(r.addr[7:4]);
      4'd4:    b = nib2asc(r.addr[3:0]);
      4'd5:    b = r.write ? ASCII_SP : ASCII_NL;
      4'd6:    b = nib2asc(r.wdata[7:4]);
      4'd7:    b = nib2asc(r.wdata[3:0]);
      default: b = ASCII_NL;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_rsp_parser.sv
// Parses a "hh\n" / error reply from the rx byte stream with a reply timeout.
// Completion outputs are combinational so the owner can register them directly.
module uart_rsp_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [BYTE_W-1:0] i_rx_byte,
  input  logic              i_rx_vld,
  output logic              o_done_c,
  output logic              o_err_c,
  output logic              o_timeout_c,
  output logic [BYTE_W-1:0] o_rdata_c
);

  rsp_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [NIB_W-1:0]  r_hi;
  logic [NIB_W-1:0]  r_lo;

  logic              w_busy;
  logic              w_nl;
  logic              w_hex;
  logic              w_tmo;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_busy    = (r_state != P_IDLE);
  assign w_nl      = i_rx_vld && (i_rx_byte == ASCII_NL);
  assign w_hex     = is_hex(i_rx_byte);
  assign w_cnt_inc = (r_cnt >= TIMEOUT_CYCLES) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_tmo     = w_busy && (w_cnt_inc == TIMEOUT_CYCLES);

  // A terminating '\n' takes priority over a timeout in the same cycle
  always_comb begin
    o_done_c    = 1'b0;
    o_err_c     = 1'b0;
    o_timeout_c = 1'b0;
    o_rdata_c   = '0;
    if (w_nl && (r_state == P_WAIT_NL)) begin
      o_done_c  = 1'b1;
      o_rdata_c = {r_hi, r_lo};
    end else if (w_nl && (r_state == P_DRAIN)) begin
      o_done_c = 1'b1;
      o_err_c  = 1'b1;
    end else if (w_tmo && !w_nl) begin
      o_done_c    = 1'b1;
      o_err_c     = 1'b1;
      o_timeout_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= P_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (i_start) begin
      r_state <= P_WAIT_HI;
      r_cnt   <= '0;
    end else if (o_done_c) begin
      r_state <= P_IDLE;
    end else if (w_busy) begin
      r_cnt <= w_cnt_inc;
      if (i_rx_vld) begin
        case (r_state)
          P_WAIT_HI: begin
            if (w_hex) begin
              r_hi    <= asc2nib(i_rx_byte);
              r_state <= P_WAIT_LO;
            end else begin
              r_state <= P_DRAIN;
            end
          end
          P_WAIT_LO: begin
            if (w_hex) begin
              r_lo    <= asc2nib(i_rx_byte);
              r_state <= P_WAIT_NL;
            end else begin
              r_state <= P_DRAIN;
            end
          end
          P_WAIT_NL: r_state <= P_DRAIN;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_cmd_master.sv
// Host-side initiator: turns read/write requests into ASCII commands on the
// UART tx byte stream and returns read data parsed from the rx reply.
module uart_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [BYTE_W-1:0] req_addr,
  input  logic [BYTE_W-1:0] req_wdata,
  output logic [BYTE_W-1:0] tx_byte,
  output logic              tx_vld,
  input  logic              tx_rdy,
  input  logic [BYTE_W-1:0] rx_byte,
  input  logic              rx_vld,
  output logic              rsp_valid,
  output logic [BYTE_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout
);

  mst_state_e        r_state;
  cmd_req_t          r_req;
  logic [IDX_W-1:0]  r_idx;

  cmd_req_t          w_new_req;
  logic              w_tx_fire;
  logic              w_last;
  logic              w_start;
  logic              w_p_done;
  logic              w_p_err;
  logic              w_p_tmo;
  logic [BYTE_W-1:0] w_p_rdata;

  assign w_new_req = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign w_tx_fire = tx_vld && tx_rdy;
  assign w_last    = (r_idx == (r_req.write ? WR_LAST_IDX : RD_LAST_IDX));
  assign w_start   = (r_state == M_SEND) && w_tx_fire && w_last && !r_req.write;

  uart_rsp_parser #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_parser (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_start),
    .i_rx_byte   (rx_byte),
    .i_rx_vld    (rx_vld),
    .o_done_c    (w_p_done),
    .o_err_c     (w_p_err),
    .o_timeout_c (w_p_tmo),
    .o_rdata_c   (w_p_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= M_IDLE;
      r_req       <= '0;
      r_idx       <= '0;
      req_ready   <= 1'b1;
      tx_vld      <= 1'b0;
      tx_byte     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      case (r_state)
        M_IDLE: begin
          if (req_valid && req_ready) begin
            r_req     <= w_new_req;
            r_idx     <= '0;
            req_ready <= 1'b0;
            tx_vld    <= 1'b1;
            tx_byte   <= cmd_byte(w_new_req, IDX_W'(0));
            r_state   <= M_SEND;
          end
        end
        M_SEND: begin
          if (w_tx_fire) begin
            if (w_last) begin
              tx_vld  <= 1'b0;
              tx_byte <= '0;
              // Writes have no ack on the wire, so they complete on the last byte
              if (r_req.write) begin
                rsp_valid <= 1'b1;
                r_state   <= M_DONE;
              end else begin
                r_state <= M_WAIT;
              end
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              tx_byte <= cmd_byte(r_req, r_idx + IDX_W'(1));
            end
          end
        end
        M_WAIT: begin
          if (w_p_done) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= w_p_err;
            rsp_timeout <= w_p_tmo;
            rsp_rdata   <= w_p_rdata;
            r_state     <= M_DONE;
          end
        end
        M_DONE: begin
          req_ready <= 1'b1;
          r_state   <= M_IDLE;
        end
        default: r_state <= M_IDLE;
      endcase
    end
  end

endmodule
